// File: rtl/vext_pkg.sv
// vext_pkg: shared types and helpers for the vector integer-extension unit.
// Honours VEXT_SPLAT_EN (frac code 0 becomes a legal scalar/imm splat).
`default_nettype none

package vext_pkg;

    typedef enum logic [1:0] {
        SEW8  = 2'd0,
        SEW16 = 2'd1,
        SEW32 = 2'd2,
        SEW64 = 2'd3
    } sew_e;

    typedef enum logic [1:0] {
        FRAC_SPLAT = 2'd0,
        FRAC_VF2   = 2'd1,
        FRAC_VF4   = 2'd2,
        FRAC_VF8   = 2'd3
    } frac_e;

    // Source width is SEW >> frac; it must stay at least one byte.
    function automatic logic vext_illegal(input sew_e sew, input frac_e frac);
        if (frac == FRAC_SPLAT) begin
`ifdef VEXT_SPLAT_EN
            return 1'b0;
`else
            return 1'b1;
`endif
        end
        return (int'(sew) < int'(frac));
    endfunction

    // log2 of the source element width in bits (splat reads a full SEW value).
    function automatic int vext_src_log2(input sew_e sew, input frac_e frac);
        return 3 + int'(sew) - int'(frac);
    endfunction

    function automatic int vext_src_width(input sew_e sew, input frac_e frac);
        return 1 << vext_src_log2(sew, frac);
    endfunction

    function automatic logic [3:0] vext_beats(input frac_e frac);
        return 4'd1 << frac;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vext_lane.sv
// vext_lane: produces one destination byte of the extended beat, either from
// the widened source element that covers it or from the splat value.
`default_nettype none

module vext_lane
    import vext_pkg::*;
#(
    parameter int DW   = 128,
    parameter int LANE = 0
) (
    input  logic [DW-1:0] i_data,
    input  sew_e          i_sew,
    input  frac_e         i_frac,
    input  logic          i_signed,
    input  logic [2:0]    i_beat,
    input  logic          i_splat,
    input  logic [63:0]   i_splat_val,
    output logic [7:0]    o_byte
);

    localparam int C_BYTES_LG = $clog2(DW / 8);

    int          w_elem;
    int          w_byte;
    int          w_src_lg;
    int          w_base;
    logic [63:0] w_shift;
    logic [63:0] w_mask;
    logic [63:0] w_ext;
    logic [63:0] w_pick;
    logic [63:0] w_sel;

    always_comb begin
        w_elem   = LANE >> int'(i_sew);
        w_byte   = LANE - (w_elem << int'(i_sew));
        w_src_lg = vext_src_log2(i_sew, i_frac);
        if (w_src_lg < 3) w_src_lg = 3;
        // Source element index = beat * (elements per beat) + element.
        w_base   = ((int'(i_beat) << (C_BYTES_LG - int'(i_sew))) + w_elem) << w_src_lg;
        w_shift  = 64'(i_data >> w_base);
        w_mask   = (64'd1 << (1 << w_src_lg)) - 64'd1;
        w_ext    = w_shift & w_mask;
        if (i_signed && (((w_ext >> ((1 << w_src_lg) - 1)) & 64'd1) != 64'd0)) begin
            w_ext = w_ext | ~w_mask;
        end
        w_pick   = i_splat ? i_splat_val : w_ext;
        w_sel    = w_pick >> (8 * w_byte);
        o_byte   = w_sel[7:0];
    end

endmodule

`default_nettype wire

// File: rtl/vext_unit.sv
// vext_unit: vsext/vzext.vf2/vf4/vf8 streaming extender with valid/ready flow.
// VEXT_SPLAT_EN: frac code 0 splats an extended scalar/simm5 over one beat.
`default_nettype none

module vext_unit
    import vext_pkg::*;
#(
    parameter int DW = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [1:0]    in_sew,
    input  logic [1:0]    in_frac,
    input  logic          in_signed,
    input  logic [31:0]   in_scalar,
    input  logic [4:0]    in_simm5,
    input  logic          in_use_imm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          err
);

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_BUSY = 1'b1;

    logic [0:0]    r_state;
    logic [0:0]    w_next_state;
    logic [DW-1:0] r_data;
    sew_e          r_sew;
    frac_e         r_frac;
    logic          r_signed;
    logic [2:0]    r_beat;
    logic          r_err;
    logic          r_splat;
    logic [63:0]   r_splat_val;

    logic          w_accept;
    logic          w_legal;
    logic          w_fire;
    logic          w_done;
    logic [2:0]    w_last_idx;
    logic          w_splat_req;
    logic [63:0]   w_splat_val;
    logic [DW-1:0] w_lane_data;

    assign w_legal    = !vext_illegal(sew_e'(in_sew), frac_e'(in_frac));
    assign w_accept   = in_valid && in_ready;
    assign w_fire     = out_valid && out_ready;
    assign w_done     = w_fire && out_last;
    assign w_last_idx = 3'(vext_beats(r_frac) - 4'd1);

`ifdef VEXT_SPLAT_EN
    assign w_splat_req = (in_frac == 2'd0);
    assign w_splat_val = in_use_imm ? {{59{in_signed & in_simm5[4]}}, in_simm5}
                                    : {{32{in_signed & in_scalar[31]}}, in_scalar};
`else
    logic w_unused_splat;
    assign w_splat_req    = 1'b0;
    assign w_splat_val    = 64'd0;
    assign w_unused_splat = ^{in_scalar, in_simm5, in_use_imm};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= STATE_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            STATE_IDLE: if (w_accept && w_legal) w_next_state = STATE_BUSY;
            STATE_BUSY: if (w_done) w_next_state = (w_accept && w_legal) ? STATE_BUSY : STATE_IDLE;
            default:    w_next_state = STATE_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (r_state == STATE_BUSY);
        out_last  = out_valid && (r_beat == w_last_idx);
        in_ready  = (r_state == STATE_IDLE) || w_done;
        err       = r_err;
        out_data  = out_valid ? w_lane_data : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data      <= '0;
            r_sew       <= SEW8;
            r_frac      <= FRAC_SPLAT;
            r_signed    <= 1'b0;
            r_beat      <= 3'd0;
            r_err       <= 1'b0;
            r_splat     <= 1'b0;
            r_splat_val <= 64'd0;
        end else begin
            r_err <= w_accept && !w_legal;
            if (w_accept && w_legal) begin
                r_data      <= in_data;
                r_sew       <= sew_e'(in_sew);
                r_frac      <= frac_e'(in_frac);
                r_signed    <= in_signed;
                r_beat      <= 3'd0;
                r_splat     <= w_splat_req;
                r_splat_val <= w_splat_val;
            end else if (w_fire && !out_last) begin
                r_beat <= r_beat + 3'd1;
            end
        end
    end

    for (genvar j = 0; j < DW / 8; j++) begin : g_lane
        vext_lane #(
            .DW   (DW),
            .LANE (j)
        ) u_lane (
            .i_data      (r_data),
            .i_sew       (r_sew),
            .i_frac      (r_frac),
            .i_signed    (r_signed),
            .i_beat      (r_beat),
            .i_splat     (r_splat),
            .i_splat_val (r_splat_val),
            .o_byte      (w_lane_data[8*j +: 8])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_vext_unit.sv
// tb_vext_unit: directed self-checking bench for vext_unit (DW=128).
`default_nettype none

module tb_vext_unit;

    localparam int DW = 128;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [1:0]    in_sew;
    logic [1:0]    in_frac;
    logic          in_signed;
    logic [31:0]   in_scalar;
    logic [4:0]    in_simm5;
    logic          in_use_imm;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          err;

    int n_tests = 0;
    int n_fail  = 0;

    vext_unit #(.DW(DW)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sew     (in_sew),
        .in_frac    (in_frac),
        .in_signed  (in_signed),
        .in_scalar  (in_scalar),
        .in_simm5   (in_simm5),
        .in_use_imm (in_use_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input logic [1:0] sew, input logic [1:0] frac,
                             input logic sgn, input logic [DW-1:0] data);
        in_sew    = sew;
        in_frac   = frac;
        in_signed = sgn;
        in_data   = data;
        in_valid  = 1'b1;
    endtask

    task automatic send(input string tag, input logic [1:0] sew, input logic [1:0] frac,
                        input logic sgn, input logic [DW-1:0] data);
        drive_req(sew, frac, sgn, data);
        chk({tag, "_in_ready"}, DW'(in_ready), DW'(1'b1));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_beat(input string tag, input logic [DW-1:0] exp, input logic last);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_valid"}, DW'(out_valid), DW'(1'b1));
        chk({tag, "_data"}, out_data, exp);
        chk({tag, "_last"}, DW'(out_last), DW'(last));
        @(posedge clk); #1;
    endtask

    logic [DW-1:0] bp_data;
    logic [DW-1:0] bp_beat [4];

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_sew     = 2'd0;
        in_frac    = 2'd0;
        in_signed  = 1'b0;
        in_scalar  = 32'd0;
        in_simm5   = 5'd0;
        in_use_imm = 1'b0;
        out_ready  = 1'b1;

        bp_data    = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
        bp_beat[0] = 128'h00000033_00000022_00000011_00000000;
        bp_beat[1] = 128'h00000077_00000066_00000055_00000044;
        bp_beat[2] = 128'hFFFFFFBB_FFFFFFAA_FFFFFF99_FFFFFF88;
        bp_beat[3] = 128'hFFFFFFFF_FFFFFFEE_FFFFFFDD_FFFFFFCC;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", DW'(out_valid), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_last", DW'(out_last), '0);
        chk("rst_err", DW'(err), '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", DW'(in_ready), DW'(1'b1));

        // vsext.vf2, SEW=16
        send("sx2", 2'd1, 2'd1, 1'b1, 128'h7F80);
        expect_beat("sx2_b0", 128'h007F_FF80, 1'b0);
        expect_beat("sx2_b1", '0, 1'b1);
        chk("sx2_done", DW'(out_valid), '0);

        // vzext.vf8, SEW=64
        send("zx8", 2'd3, 2'd3, 1'b0, 128'h8100_00F0);
        expect_beat("zx8_b0", {64'h0, 64'hF0}, 1'b0);
        expect_beat("zx8_b1", {64'h81, 64'h0}, 1'b0);
        for (int b = 2; b < 8; b++) begin
            expect_beat($sformatf("zx8_b%0d", b), '0, (b == 7));
        end
        chk("zx8_done", DW'(out_valid), '0);

        // vsext.vf4, SEW=32 with a 3-cycle stall on beat 1
        send("bp", 2'd2, 2'd2, 1'b1, bp_data);
        expect_beat("bp_b0", bp_beat[0], 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_valid", DW'(out_valid), DW'(1'b1));
            chk("bp_hold_data", out_data, bp_beat[1]);
            chk("bp_hold_last", DW'(out_last), '0);
            chk("bp_hold_in_ready", DW'(in_ready), '0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        chk("bp_in_ready_midbeat", DW'(in_ready), '0);
        expect_beat("bp_b1", bp_beat[1], 1'b0);
        expect_beat("bp_b2", bp_beat[2], 1'b0);
        expect_beat("bp_b3", bp_beat[3], 1'b1);
        chk("bp_done", DW'(out_valid), '0);

        // Back-to-back: request B queued while A streams, accepted on A's last beat
        drive_req(2'd3, 2'd1, 1'b0, 128'h80000001_FFFFFFFE);
        @(posedge clk); #1;
        drive_req(2'd3, 2'd1, 1'b1, 128'h80000001_FFFFFFFE);
        chk("b2b_a0_data", out_data, {64'h80000001, 64'hFFFFFFFE});
        chk("b2b_a0_in_ready", DW'(in_ready), '0);
        @(posedge clk); #1;
        chk("b2b_a1_data", out_data, '0);
        chk("b2b_a1_last", DW'(out_last), DW'(1'b1));
        chk("b2b_a1_in_ready", DW'(in_ready), DW'(1'b1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b_b0_valid", DW'(out_valid), DW'(1'b1));
        chk("b2b_b0_data", out_data, {64'hFFFFFFFF80000001, 64'hFFFFFFFFFFFFFFFE});
        expect_beat("b2b_b0", {64'hFFFFFFFF80000001, 64'hFFFFFFFFFFFFFFFE}, 1'b0);
        expect_beat("b2b_b1", '0, 1'b1);
        chk("b2b_done", DW'(out_valid), '0);

        // Illegal: SEW=8 vf2
        send("ill", 2'd0, 2'd1, 1'b0, 128'hFF);
        chk("ill_err", DW'(err), DW'(1'b1));
        chk("ill_valid", DW'(out_valid), '0);
        chk("ill_in_ready", DW'(in_ready), DW'(1'b1));
        @(posedge clk); #1;
        chk("ill_err_clear", DW'(err), '0);
        chk("ill_valid_after", DW'(out_valid), '0);

        // Splat of simm5 = 0x10 sign-extended at SEW=32
        in_simm5   = 5'h10;
        in_use_imm = 1'b1;
        in_scalar  = 32'h1234_5678;
        send("spl", 2'd2, 2'd0, 1'b1, '0);
`ifdef VEXT_SPLAT_EN
        chk("spl_err", DW'(err), '0);
        expect_beat("spl_b0", {4{32'hFFFFFFF0}}, 1'b1);
        chk("spl_done", DW'(out_valid), '0);
`else
        chk("spl_err", DW'(err), DW'(1'b1));
        chk("spl_valid", DW'(out_valid), '0);
        @(posedge clk); #1;
        chk("spl_err_clear", DW'(err), '0);
        chk("spl_valid_after", DW'(out_valid), '0);
`endif
        in_use_imm = 1'b0;

        // Reset during beat 1 of a vf4 request
        send("rs", 2'd2, 2'd2, 1'b1, bp_data);
        expect_beat("rs_b0", bp_beat[0], 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_valid", DW'(out_valid), '0);
        chk("rs_data", out_data, '0);
        chk("rs_last", DW'(out_last), '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rs_in_ready", DW'(in_ready), DW'(1'b1));
        chk("rs_idle", DW'(out_valid), '0);
        send("rs_new", 2'd1, 2'd1, 1'b1, 128'h7F80);
        expect_beat("rs_new_b0", 128'h007F_FF80, 1'b0);
        expect_beat("rs_new_b1", '0, 1'b1);
        chk("rs_new_done", DW'(out_valid), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
